// File: rtl/id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage
//
// ID/EX pipeline register that sits directly behind the register file's
// combinational read ports. It captures the decoded instruction together with
// its two source operands, and it handles the following cases:
//   - Same-cycle writeback bypass. The register file writes on the clock edge
//     and has no write-through, so a value being written this cycle must be
//     forwarded here.
//   - Load-use hazards. The stage inserts a one-cycle bubble and holds IF/ID.
//   - Back-end stall. The register holds, and the held operands are refreshed
//     from writeback.
//   - Branch/jump flush. Flush has the highest priority.
//
// Optional feature (macro OPSTAGE_PERF_CNT_EN):
//   Adds the perf_bubbles and perf_stalls event counters and their ports.
//
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   id_valid .. id_ctrl         decoded instruction from ID
//   rf_rdata1, rf_rdata2        register file read data
//   wb_we, wb_rd, wb_wdata      writeback port (bypass/refresh source)
//   ex_stall                    back-end stall
//   flush                       kill the instruction entering EX
//   ex_*                        registered EX-stage fields
//   id_stall                    combinational; hold IF/ID
//   perf_bubbles, perf_stalls   registered event counters (optional)
// -----------------------------------------------------------------------------
module id_ex_operand_stage #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned CTRL_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   // decoded instruction from ID
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic [4:0]        id_rd,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic              id_mem_read,
   input  logic [CTRL_W-1:0] id_ctrl,
   // register file read data
   input  logic [XLEN-1:0]   rf_rdata1,
   input  logic [XLEN-1:0]   rf_rdata2,
   // writeback
   input  logic              wb_we,
   input  logic [4:0]        wb_rd,
   input  logic [XLEN-1:0]   wb_wdata,
   // pipeline control
   input  logic              ex_stall,
   input  logic              flush,
   // EX-stage outputs
   output logic              ex_valid,
   output logic              ex_mem_read,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_imm,
   output logic [XLEN-1:0]   ex_op1,
   output logic [XLEN-1:0]   ex_op2,
   output logic [4:0]        ex_rs1,
   output logic [4:0]        ex_rs2,
   output logic [4:0]        ex_rd,
   output logic [CTRL_W-1:0] ex_ctrl,
`ifdef OPSTAGE_PERF_CNT_EN
   output logic [31:0]       perf_bubbles,
   output logic [31:0]       perf_stalls,
`endif
   output logic              id_stall
);

   localparam int unsigned RA_W = 5;

   // EX-stage state
   logic              ex_valid_q,    ex_valid_d;
   logic              ex_mem_read_q, ex_mem_read_d;
   logic [XLEN-1:0]   ex_pc_q,       ex_pc_d;
   logic [XLEN-1:0]   ex_imm_q,      ex_imm_d;
   logic [XLEN-1:0]   ex_op1_q,      ex_op1_d;
   logic [XLEN-1:0]   ex_op2_q,      ex_op2_d;
   logic [RA_W-1:0]   ex_rs1_q,      ex_rs1_d;
   logic [RA_W-1:0]   ex_rs2_q,      ex_rs2_d;
   logic [RA_W-1:0]   ex_rd_q,       ex_rd_d;
   logic [CTRL_W-1:0] ex_ctrl_q,     ex_ctrl_d;

   logic [XLEN-1:0]   op1_c;
   logic [XLEN-1:0]   op2_c;
   logic              hazard_c;
   logic              wb_live_c;

   // A writeback to x0 never bypasses and never refreshes
   assign wb_live_c = wb_we && (wb_rd != RA_W'(0));

   // Operand select: x0 reads as zero, then the same-cycle writeback, then the RF
   always_comb begin
      op1_c = rf_rdata1;
      op2_c = rf_rdata2;
      if (id_rs1 == RA_W'(0)) begin
         op1_c = '0;
      end else if (wb_live_c && (wb_rd == id_rs1)) begin
         op1_c = wb_wdata;
      end
      if (id_rs2 == RA_W'(0)) begin
         op2_c = '0;
      end else if (wb_live_c && (wb_rd == id_rs2)) begin
         op2_c = wb_wdata;
      end
   end

   // Load-use: a load in EX whose destination is a source the ID instruction reads
   always_comb begin
      hazard_c = id_valid && ex_valid_q && ex_mem_read_q && (ex_rd_q != RA_W'(0)) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd_q)) ||
                  (id_use_rs2 && (id_rs2 == ex_rd_q)));
   end

   // Flush kills the ID instruction anyway, so ID must not be held on top of that
   assign id_stall = !flush && (ex_stall || hazard_c);

   // Next-state: flush > stall (hold + refresh) > bubble > load
   always_comb begin
      ex_valid_d    = ex_valid_q;
      ex_mem_read_d = ex_mem_read_q;
      ex_pc_d       = ex_pc_q;
      ex_imm_d      = ex_imm_q;
      ex_op1_d      = ex_op1_q;
      ex_op2_d      = ex_op2_q;
      ex_rs1_d      = ex_rs1_q;
      ex_rs2_d      = ex_rs2_q;
      ex_rd_d       = ex_rd_q;
      ex_ctrl_d     = ex_ctrl_q;

      if (flush) begin
         ex_valid_d    = 1'b0;
         ex_mem_read_d = 1'b0;
         ex_ctrl_d     = '0;
      end else if (ex_stall) begin
         // The held instruction must still see results that retire while it waits
         if (wb_live_c && (wb_rd == ex_rs1_q)) begin
            ex_op1_d = wb_wdata;
         end
         if (wb_live_c && (wb_rd == ex_rs2_q)) begin
            ex_op2_d = wb_wdata;
         end
      end else if (hazard_c) begin
         ex_valid_d    = 1'b0;
         ex_mem_read_d = 1'b0;
         ex_ctrl_d     = '0;
      end else begin
         ex_valid_d    = id_valid;
         ex_mem_read_d = id_valid && id_mem_read;
         ex_ctrl_d     = id_valid ? id_ctrl : '0;
         ex_pc_d       = id_pc;
         ex_imm_d      = id_imm;
         ex_op1_d      = op1_c;
         ex_op2_d      = op2_c;
         ex_rs1_d      = id_rs1;
         ex_rs2_d      = id_rs2;
         ex_rd_d       = id_rd;
      end
   end

   // EX-stage register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_q    <= 1'b0;
         ex_mem_read_q <= 1'b0;
         ex_pc_q       <= '0;
         ex_imm_q      <= '0;
         ex_op1_q      <= '0;
         ex_op2_q      <= '0;
         ex_rs1_q      <= '0;
         ex_rs2_q      <= '0;
         ex_rd_q       <= '0;
         ex_ctrl_q     <= '0;
      end else begin
         ex_valid_q    <= ex_valid_d;
         ex_mem_read_q <= ex_mem_read_d;
         ex_pc_q       <= ex_pc_d;
         ex_imm_q      <= ex_imm_d;
         ex_op1_q      <= ex_op1_d;
         ex_op2_q      <= ex_op2_d;
         ex_rs1_q      <= ex_rs1_d;
         ex_rs2_q      <= ex_rs2_d;
         ex_rd_q       <= ex_rd_d;
         ex_ctrl_q     <= ex_ctrl_d;
      end
   end

   assign ex_valid    = ex_valid_q;
   assign ex_mem_read = ex_mem_read_q;
   assign ex_pc       = ex_pc_q;
   assign ex_imm      = ex_imm_q;
   assign ex_op1      = ex_op1_q;
   assign ex_op2      = ex_op2_q;
   assign ex_rs1      = ex_rs1_q;
   assign ex_rs2      = ex_rs2_q;
   assign ex_rd       = ex_rd_q;
   assign ex_ctrl     = ex_ctrl_q;

`ifdef OPSTAGE_PERF_CNT_EN
   logic [31:0] perf_bubbles_q, perf_bubbles_d;
   logic [31:0] perf_stalls_q,  perf_stalls_d;

   // Count the edges that actually bubble or hold; a flush overrides both. Counters wrap.
   always_comb begin
      perf_bubbles_d = perf_bubbles_q;
      perf_stalls_d  = perf_stalls_q;
      if (!flush && ex_stall) begin
         perf_stalls_d = perf_stalls_q + 32'd1;
      end
      if (!flush && !ex_stall && hazard_c) begin
         perf_bubbles_d = perf_bubbles_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_bubbles_q <= '0;
         perf_stalls_q  <= '0;
      end else begin
         perf_bubbles_q <= perf_bubbles_d;
         perf_stalls_q  <= perf_stalls_d;
      end
   end

   assign perf_bubbles = perf_bubbles_q;
   assign perf_stalls  = perf_stalls_q;
`endif

endmodule
